// File: rtl/toom8_recompose.sv
`timescale 1ns/1ps
// Toom-8 final recomposition: divides each 13!-scaled coefficient exactly by 13!
// with a bit-serial restoring divider, then overlap-adds it at its limb weight.
module toom8_recompose #(
  parameter int               LIMB_W  = 128,
  parameter int               PROD_W  = 2048,
  parameter int               COEF_W  = 384,
  parameter int               DIV_W   = 33,
  parameter logic [DIV_W-1:0] DIV_VAL = 33'd6227020800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_in,
  output logic              prod_valid,
  input  logic              prod_ready,
  output logic [PROD_W-1:0] prod_out,
  output logic              err_inexact,
  output logic              err_range
);

  localparam int         ACC_W    = 14*LIMB_W + COEF_W + 4;
  localparam int         CNT_W    = $clog2(COEF_W);
  localparam logic [3:0] LAST_IDX = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ACC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  // Starts as |coef|; dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [COEF_W-1:0] quot_q, quot_d;
  logic [DIV_W-1:0]  rem_q, rem_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              err_inexact_q, err_inexact_d;
  logic              err_range_q, err_range_d;

  logic [DIV_W:0]    trial;
  logic              trial_ge;
  logic [COEF_W:0]   q_val;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  acc_sum;
  logic [11:0]       shift_amt;

  // Datapath: one restoring-division step and the limb-weighted accumulate.
  always_comb begin
    trial     = {rem_q, quot_q[COEF_W-1]};
    trial_ge  = (trial >= {1'b0, DIV_VAL});
    q_val     = sign_q ? -{1'b0, quot_q} : {1'b0, quot_q};
    addend    = {{(ACC_W-COEF_W-1){q_val[COEF_W]}}, q_val};
    shift_amt = 12'(idx_q) * 12'(LIMB_W);
    acc_sum   = acc_q + (addend << shift_amt);
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    sign_d        = sign_q;
    quot_d        = quot_q;
    rem_d         = rem_q;
    acc_d         = acc_q;
    err_inexact_d = err_inexact_q;
    err_range_d   = err_range_q;
    coef_ready    = 1'b0;
    prod_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          sign_d  = coef_in[COEF_W-1];
          quot_d  = coef_in[COEF_W-1] ? -coef_in : coef_in;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
          if (idx_q == 4'd0) begin
            acc_d         = '0;
            err_inexact_d = 1'b0;
            err_range_d   = 1'b0;
          end
        end
      end

      S_DIV: begin
        if (trial_ge) begin
          rem_d  = DIV_W'(trial - {1'b0, DIV_VAL});
          quot_d = {quot_q[COEF_W-2:0], 1'b1};
        end else begin
          rem_d  = trial[DIV_W-1:0];
          quot_d = {quot_q[COEF_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(COEF_W-1)) state_d = S_ACC;
      end

      S_ACC: begin
        acc_d = acc_sum;
        if (rem_q != '0) err_inexact_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          // Sign bit or any bit above the product width means the result does not fit.
          err_range_d = acc_sum[ACC_W-1] | (|acc_sum[ACC_W-1:PROD_W]);
          state_d     = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        prod_valid = 1'b1;
        if (prod_ready) begin
          idx_d   = 4'd0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      quot_q        <= '0;
      rem_q         <= '0;
      acc_q         <= '0;
      err_inexact_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      sign_q        <= sign_d;
      quot_q        <= quot_d;
      rem_q         <= rem_d;
      acc_q         <= acc_d;
      err_inexact_q <= err_inexact_d;
      err_range_q   <= err_range_d;
    end
  end

  assign prod_out    = acc_q[PROD_W-1:0];
  assign err_inexact = err_inexact_q;
  assign err_range   = err_range_q;

endmodule

// File: tb/tb_toom8_recompose.sv
`timescale 1ns/1ps
// Self-checking bench for toom8_recompose: directed frames plus randomized frames
// checked against a signed-division / weighted-sum reference model.
module tb_toom8_recompose;

  localparam int LIMB_W = 128;
  localparam int PROD_W = 2048;
  localparam int COEF_W = 384;
  localparam int NCOEF  = 15;
  localparam int SUM_W  = 2200;
  localparam logic [COEF_W-1:0] DIVISOR = 384'd6227020800;

  logic              clk;
  logic              rst_n;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_out;
  logic              err_inexact;
  logic              err_range;

  toom8_recompose dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_in    (coef_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_out   (prod_out),
    .err_inexact(err_inexact),
    .err_range  (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [COEF_W-1:0] frame_c [NCOEF];
  logic [PROD_W-1:0] exp_prod;
  logic              exp_inexact;
  logic              exp_range;

  task automatic check(input string tag, input logic [PROD_W-1:0] got, input logic [PROD_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      int k;
      k = 0;
      for (int i = PROD_W/LIMB_W-1; i >= 0; i--)
        if (got[i*LIMB_W +: LIMB_W] !== exp[i*LIMB_W +: LIMB_W]) k = i;
      n_fail++;
      $display("FAIL %s limb%0d got=%h exp=%h", tag, k,
               got[k*LIMB_W +: LIMB_W], exp[k*LIMB_W +: LIMB_W]);
    end
  endtask

  // Reference: exact signed quotient per coefficient, weighted by 2^(i*LIMB_W), summed.
  function automatic void compute_model();
    logic signed [COEF_W-1:0] c, q, r, dv;
    logic signed [SUM_W-1:0]  sum, term;
    dv          = DIVISOR;
    sum         = '0;
    exp_inexact = 1'b0;
    for (int i = 0; i < NCOEF; i++) begin
      c = frame_c[i];
      q = c / dv;
      r = c % dv;
      if (r != 0) exp_inexact = 1'b1;
      term = q;
      sum  = sum + (term <<< (i * LIMB_W));
    end
    exp_prod  = sum[PROD_W-1:0];
    exp_range = (sum < 0) || (sum[SUM_W-1:PROD_W] != '0);
  endfunction

  function automatic logic [COEF_W-1:0] rand_raw();
    logic [COEF_W-1:0] v;
    v = '0;
    for (int w = 0; w < COEF_W/32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [COEF_W-1:0] rand_exact(input int qbits);
    logic [COEF_W-1:0] q, mask;
    mask = '1;
    mask = mask >> (COEF_W - qbits);
    q    = rand_raw() & mask;
    if ($urandom_range(1, 0) == 1) q = -q;
    return q * DIVISOR;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < NCOEF; i++) frame_c[i] = '0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NCOEF; i++) begin
      case ($urandom_range(3, 0))
        0:       frame_c[i] = rand_raw();
        1:       frame_c[i] = '0;
        default: frame_c[i] = rand_exact(int'($urandom_range(340, 1)));
      endcase
    end
  endtask

  task automatic push(input logic [COEF_W-1:0] c);
    int n;
    n = 0;
    @(negedge clk);
    coef_in    = c;
    coef_valid = 1'b1;
    while (!coef_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", coef_ready, 1'b1);
    if (coef_ready) begin
      @(posedge clk);
      #1;
    end
    coef_valid = 1'b0;
  endtask

  task automatic push_range(input int first, input int last);
    for (int i = first; i <= last; i++) push(frame_c[i]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!prod_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("prod_valid_wait", prod_valid, 1'b1);
  endtask

  task automatic check_model(input string tag);
    compute_model();
    check({tag, "_prod"},    prod_out,    exp_prod);
    check({tag, "_inexact"}, err_inexact, exp_inexact);
    check({tag, "_range"},   err_range,   exp_range);
  endtask

  task automatic release_prod(input string tag);
    @(negedge clk);
    prod_ready = 1'b1;
    @(posedge clk);
    #1;
    prod_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, prod_valid, 1'b0);
    check({tag, "_ready_back"}, coef_ready, 1'b1);
  endtask

  task automatic load_t3();
    clear_frame();
    frame_c[0] = DIVISOR;
    frame_c[1] = DIVISOR << 1;
    frame_c[2] = DIVISOR;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog no_finish got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PROD_W-1:0] e;
    rst_n      = 1'b0;
    coef_valid = 1'b0;
    coef_in    = '0;
    prod_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_coef_ready",  coef_ready,  1'b1);
    check("rst_prod_valid",  prod_valid,  1'b0);
    check("rst_err_inexact", err_inexact, 1'b0);
    check("rst_err_range",   err_range,   1'b0);
    check("rst_prod_out",    prod_out,    '0);
    rst_n = 1'b1;

    // T1: all zero coefficients
    clear_frame();
    push_range(0, NCOEF-1);
    wait_done();
    check_model("t1");
    check("t1_zero", prod_out, '0);
    release_prod("t1");

    // T2: c0 = 5 * 13!
    clear_frame();
    frame_c[0] = DIVISOR * 5;
    push_range(0, NCOEF-1);
    wait_done();
    check_model("t2");
    check("t2_five", prod_out, PROD_W'(5));
    release_prod("t2");

    // T3: (2^128+1)^2
    load_t3();
    push_range(0, NCOEF-1);
    wait_done();
    check_model("t3");
    e = '0; e[256] = 1'b1; e[129] = 1'b1; e[0] = 1'b1;
    check("t3_square", prod_out, e);
    release_prod("t3");

    // T4: negative low coefficient, value 2^128-1
    clear_frame();
    frame_c[0] = -DIVISOR;
    frame_c[1] = DIVISOR;
    push_range(0, NCOEF-1);
    wait_done();
    check_model("t4");
    e = '0; e[LIMB_W-1:0] = '1;
    check("t4_value", prod_out, e);
    check("t4_range", err_range, 1'b0);
    release_prod("t4");

    // T5: inexact c3, sticky through DONE
    clear_frame();
    frame_c[3] = DIVISOR * 7 + 1;
    push_range(0, 3);
    check("t5_before_acc", err_inexact, 1'b0);
    push(frame_c[4]);
    check("t5_after_acc", err_inexact, 1'b1);
    push_range(5, NCOEF-1);
    wait_done();
    check_model("t5");
    e = '0; e[386:384] = 3'd7;
    check("t5_value", prod_out, e);
    release_prod("t5");

    // Random frame: first accept clears the sticky error, then backpressure with a pushy source
    rand_frame();
    push(frame_c[0]);
    check("next_frame_clear", err_inexact, 1'b0);
    push_range(1, NCOEF-1);
    wait_done();
    check_model("r1");
    for (int i = 0; i < 10; i++) begin
      coef_in    = rand_raw();
      coef_valid = 1'b1;
      @(negedge clk);
      check("bp_prod_valid", prod_valid, 1'b1);
      check("bp_prod_out",   prod_out,   exp_prod);
      check("bp_coef_ready", coef_ready, 1'b0);
    end
    coef_valid = 1'b0;
    release_prod("r1");

    // Random frame that the ignored DONE-time coefficients must not have disturbed
    rand_frame();
    push_range(0, NCOEF-1);
    wait_done();
    check_model("r2");
    release_prod("r2");

    // Reset during the c7 division, then T3 again
    rand_frame();
    frame_c[0] = DIVISOR * 3 + 5;
    push_range(0, 7);
    repeat (50) @(negedge clk);
    check("pre_rst_inexact", err_inexact, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_coef_ready",  coef_ready,  1'b1);
    check("mid_rst_prod_valid",  prod_valid,  1'b0);
    check("mid_rst_err_inexact", err_inexact, 1'b0);
    check("mid_rst_prod_out",    prod_out,    '0);
    @(negedge clk);
    rst_n = 1'b1;
    load_t3();
    push_range(0, NCOEF-1);
    wait_done();
    check_model("t6_t3");
    e = '0; e[256] = 1'b1; e[129] = 1'b1; e[0] = 1'b1;
    check("t6_t3_square", prod_out, e);
    release_prod("t6_t3");

    // Boundaries: most-negative input, zero input, overflow past 2^PROD_W
    rand_frame();
    frame_c[0] = '0;
    frame_c[0][COEF_W-1] = 1'b1;
    frame_c[1]  = '0;
    frame_c[14] = (384'd1 << 300) * DIVISOR;
    push_range(0, NCOEF-1);
    wait_done();
    check_model("b1");
    check("b1_range", err_range, 1'b1);
    release_prod("b1");

    // Boundary: negative final sum
    clear_frame();
    frame_c[5]  = rand_exact(200);
    frame_c[14] = -DIVISOR;
    push_range(0, NCOEF-1);
    wait_done();
    check_model("b2");
    check("b2_range", err_range, 1'b1);
    release_prod("b2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
